// File: rtl/mem_pkg.sv
// mem_pkg: funct3 encodings, MEM-stage FSM states and access helpers shared by the MEM stage
package mem_pkg;
    localparam int XLEN = 64;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        case (f3 & 3'b011)
            F3_B:    return 8'h01;
            F3_H:    return 8'h03;
            F3_W:    return 8'h0f;
            F3_D:    return 8'hff;
            default: return 8'h00;
        endcase
    endfunction
    // an access is misaligned when any offset bit below its natural size is set
    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        return |(off & {f3[1] & f3[0], f3[1], f3[1] | f3[0]});
    endfunction
    function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                         input logic s_less, input logic u_less);
        case (f3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            F3_BLT:  return s_less;
            F3_BGE:  return !s_less;
            F3_BLTU: return u_less;
            F3_BGEU: return !u_less;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/mem_stage_load_formatter.sv
// load_formatter: selects the addressed lane of a raw doubleword and sign/zero-extends it
// Ports: funct3 (size/sign), offset (addr[2:0]), raw (memory doubleword), data (formatted result)
module load_formatter
    import mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] lane;
    logic            sx;
    assign lane = raw >> {offset, 3'b000};
    assign sx   = !(funct3 inside {F3_BU, F3_HU, F3_WU});
    always_comb
        data = funct3[1:0] == 2'b00 ? {{56{sx & lane[7]}}, lane[7:0]}
             : funct3[1:0] == 2'b01 ? {{48{sx & lane[15]}}, lane[15:0]}
             : funct3[1:0] == 2'b10 ? {{32{sx & lane[31]}}, lane[31:0]}
             : lane;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: branch/jump resolution and data-memory load/store sequencing for the MEM stage
// Ports: MEM_* from EX/MEM; PCSrc/PCTarget/MEMflush redirect; mem_stall freezes upstream;
//        MEM_ReadData formatted load result; dmem_* req/gnt/rvalid data-memory port.
// Build option MEM_MISALIGN_CHECK_EN: adds output misalign and suppresses misaligned accesses;
//        without it, misaligned strobes/data are simply truncated to the doubleword.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic              MEM_Branch,
    input  logic              MEM_Jump,
    input  logic [XLEN-1:0]   MEM_PCSum,
    input  logic              MEM_zero,
    input  logic              MEM_s_less,
    input  logic              MEM_u_less,
    input  logic [XLEN-1:0]   MEM_ALUresult,
    input  logic [XLEN-1:0]   MEM_RegData2,
    input  logic [2:0]        MEM_funct3,
    output logic              PCSrc,
    output logic [XLEN-1:0]   PCTarget,
    output logic              MEMflush,
    output logic              mem_stall,
    output logic [XLEN-1:0]   MEM_ReadData,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [7:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);
    state_t          state_q, state_d;
    logic            access, is_store;
    logic [2:0]      off;
    logic [XLEN-1:0] fmt, rd_q;
    logic            unused_addr;
    assign off         = MEM_ALUresult[2:0];
    assign is_store    = MEM_MemWrite;
    assign unused_addr = ^MEM_ALUresult[XLEN-1:ADDR_W];
`ifdef MEM_MISALIGN_CHECK_EN
    logic mis;
    assign mis          = misaligned(MEM_funct3, off);
    assign access       = (MEM_MemRead | MEM_MemWrite) & !mis;
    assign misalign     = (MEM_MemRead | MEM_MemWrite) & mis;
    assign MEM_ReadData = misalign & !MEM_MemWrite ? '0 : rd_q;
`else
    assign access       = MEM_MemRead | MEM_MemWrite;
    assign MEM_ReadData = rd_q;
`endif
    assign PCSrc      = (MEM_Branch & branch_cond(MEM_funct3, MEM_zero, MEM_s_less, MEM_u_less)) | MEM_Jump;
    assign MEMflush   = PCSrc;
    assign PCTarget   = MEM_PCSum;
    assign dmem_addr  = {MEM_ALUresult[ADDR_W-1:3], 3'b000};
    assign dmem_be    = size_mask(MEM_funct3) << off;
    assign dmem_wdata = MEM_RegData2 << {off, 3'b000};
    assign dmem_we    = dmem_req & is_store;
    load_formatter u_fmt (
        .funct3 (MEM_funct3),
        .offset (off),
        .raw    (dmem_rdata),
        .data   (fmt)
    );
    // outputs are forced quiet while rst is held so a pending access cannot re-issue
    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req  = access;
                mem_stall = access;
                if (access) state_d = dmem_gnt ? (is_store ? DONE : WAIT) : REQ;
            end
            REQ: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                if (dmem_gnt) state_d = is_store ? DONE : WAIT;
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (dmem_rvalid) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) rd_q <= '0;
        else if (state_q == WAIT && dmem_rvalid) rd_q <= fmt;
`ifdef MEM_MISALIGN_CHECK_EN
        else if (misalign & !MEM_MemWrite) rd_q <= '0;
`endif
endmodule
